// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical counters,
// sync decode and a one-pixel registered colour/sync output stage.
module vga_timing #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] x_coords,
    output logic [9:0] y_coords,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_next;
    logic             tick_q, tick_next;
    logic [9:0]       x_q, y_q, x_next, y_next;
    logic             x_wrap, y_wrap, hs_region, vs_region;
    logic [3:0]       r_next, g_next, b_next;

    assign x_wrap      = (x_q == H_LAST);
    assign y_wrap      = (y_q == V_LAST);
    assign hs_region   = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    assign vs_region   = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    assign video_on    = (x_q < H_VIS) && (y_q < V_VIS);
    assign x_coords    = x_q;
    assign y_coords    = y_q;
    assign pixel_tick  = tick_q;
    assign frame_start = tick_q && x_wrap && y_wrap;

    // Next divider/counter state; the tick is registered one cycle ahead of its divider value.
    always_comb begin
        div_next = div_q + DIV_W'(1);
        x_next   = x_q;
        y_next   = y_q;
        if (div_q == DIV_LAST) begin
            div_next = '0;
        end
        tick_next = (div_next == DIV_LAST);
        if (tick_q) begin
            if (x_wrap) begin
                x_next = '0;
                y_next = y_wrap ? 10'd0 : y_q + 10'd1;
            end else begin
                x_next = x_q + 10'd1;
            end
        end
        r_next = video_on ? red_in   : 4'h0;
        g_next = video_on ? green_in : 4'h0;
        b_next = video_on ? blue_in  : 4'h0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            div_q  <= div_next;
            tick_q <= tick_next;
            x_q    <= x_next;
            y_q    <= y_next;
            // Colour and sync share the same one-pixel pipeline stage.
            if (tick_q) begin
                vga_r  <= r_next;
                vga_g  <= g_next;
                vga_b  <= b_next;
                vga_hs <= ~hs_region;
                vga_vs <= ~vs_region;
            end
        end
    end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, meaning the number of clock cycles per pixel (pixel tick every CLK_DIV cycles; legal values 1 to 4).
REQ-002 The block SHALL have parameters H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48, which give the horizontal pixel counts for each region.
REQ-003 The block SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, which give the vertical line counts for each region.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  clock  in  1  system clock; the block has one clock only.
  reset  in  1  asynchronous, active-high reset.
  red_in  in  4  pixel colour from the renderer for the current coordinates.
  green_in  in  4  as red_in.
  blue_in  in  4  as red_in.
  x_coords  out  10  current horizontal pixel counter.
  y_coords  out  10  current vertical line counter.
  video_on  out  1  high when x_coords < H_VISIBLE and y_coords < V_VISIBLE.
  pixel_tick  out  1  one-cycle strobe marking each pixel advance.
  frame_start  out  1  one-cycle strobe at the tick where the counters wrap to (0,0).
  vga_hs  out  1  horizontal sync to the connector, active-low.
  vga_vs  out  1  vertical sync to the connector, active-low.
  vga_r  out  4  registered colour to the DAC.
  vga_g  out  4  as vga_r.
  vga_b  out  4  as vga_r.

Function
REQ-005 The divider counter SHALL count 0 to CLK_DIV-1 and wrap; pixel_tick SHALL be high for the cycle in which the divider equals CLK_DIV-1 (with CLK_DIV=1 it is always high).
REQ-006 x_coords SHALL increment on each pixel_tick and wrap from H_TOTAL-1 to 0, where H_TOTAL = sum of the H parameters (800).
REQ-007 y_coords SHALL increment on the pixel_tick where x_coords wraps, and wrap from V_TOTAL-1 to 0, where V_TOTAL = 525.
REQ-008 Both coordinate counters SHALL hold their value on cycles without pixel_tick.
REQ-009 frame_start SHALL be high for exactly one cycle: the pixel_tick cycle where x_coords = H_TOTAL-1 and y_coords = V_TOTAL-1.
REQ-010 The horizontal sync region SHALL be x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751].
REQ-011 The vertical sync region SHALL be y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490, 491].
REQ-012 video_on, x_coords and y_coords SHALL be combinational from the counters, so the renderer answers red_in/green_in/blue_in within the same pixel period.
REQ-013 On each pixel_tick, vga_r/g/b SHALL register red_in/green_in/blue_in when video_on is high, else 0.
REQ-014 On each pixel_tick, vga_hs and vga_vs SHALL register the inverted sync-region decode, so colour and sync share the same one-pixel latency.
REQ-015 Pixel latency SHALL be exactly one pixel: the colour for coordinate (x,y) appears on vga_r/g/b starting at the tick after (x,y) is presented.
REQ-016 The registered outputs SHALL hold their value between ticks.
REQ-017 Colour inputs during blanking SHALL be ignored.
REQ-018 All comparisons SHALL be unsigned 10-bit; the counters SHALL never exceed their TOTAL-1.

Reset
REQ-019 Asserting reset at any time, including mid-line or mid-frame, SHALL immediately force divider=0, x_coords=0, y_coords=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, pixel_tick=0 and frame_start=0.
REQ-020 After reset deasserts, the first pixel_tick SHALL occur CLK_DIV cycles later, and counting SHALL resume from (0,0).

Verification
REQ-021 Line timing: with CLK_DIV=2, measure vga_hs after reset -> period 1600 clocks, low for 192 clocks, first falling edge at pixel 657 (one-pixel latency).
REQ-022 Frame timing: run two frames -> vga_vs low for 2 lines (1600 clocks per line); frame_start pulses are exactly 840000 clocks apart.
REQ-023 Colour gating: drive red_in=4'hF constantly -> vga_r=F only for 640 pixels per line and 480 lines per frame, and 0 in blanking.
REQ-024 Alignment: drive red_in = x_coords[3:0] -> at every tick in visible area, vga_r equals the previous pixel's x[3:0].
REQ-025 Mid-frame reset: assert reset at y=200, x=300 for 3 cycles -> all outputs at their reset values asynchronously, and the next frame starts from (0,0) after CLK_DIV cycles.
REQ-026 Wrap: observe the counter wrap points -> x goes 799 to 0 with y incrementing; at (799,524) the counters go to (0,0) with frame_start=1 for one cycle.
